// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : IF/ID pipeline register of the 5-stage MIPS core with
//               built-in load-use hazard detection. Captures PC+4 and the
//               fetched instruction, holds them on a load-use hazard or an
//               external stall, and loads a NOP bubble when the instruction
//               being fetched is squashed.
//
// Ports       : clk_i           clock, all state on posedge
//               rst_n_i         synchronous reset, active-low
//               pc_i            PC+4 from IF
//               instr_i         fetched instruction
//               hold_i          external stall, freezes the register
//               flush_i         squash the instruction being fetched
//               idex_memread_i  MemRead bit currently held in ID/EX
//               idex_rt_i       load destination register held in ID/EX
//               pc_o            registered PC+4
//               instr_o         registered instruction
//               valid_o         1 = real instruction, 0 = bubble
//               stall_o         load-use hazard (combinational)
//               bubble_o        zero the control word going into ID/EX
//               pc_write_o      PC register enable
//               stall_cnt_o     load-use stall cycles (performance counter)
//               flush_cnt_o     flushes performed (performance counter)
//
// Options     : IF_ID_PERF_CNT_EN - when defined, stall_cnt_o/flush_cnt_o
//               are saturating counters; otherwise both are tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      instr_o,
    output logic             valid_o,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             pc_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Opcodes whose rt field is a source operand (R-type, beq, bne, sw).
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_uses_rt;
    logic        w_stall;

    // ------------------------------------------------------------------
    // Load-use hazard: looks only at registered state plus the ID/EX
    // fields, so a bubble (valid_q=0) can never request a stall.
    // ------------------------------------------------------------------
    always_comb begin
        w_op      = instr_q[31:26];
        w_rs      = instr_q[25:21];
        w_rt      = instr_q[20:16];
        w_uses_rt = 1'b0;
        case (w_op)
            c_OP_RTYPE, c_OP_BEQ, c_OP_BNE, c_OP_SW: w_uses_rt = 1'b1;
            default:                                 w_uses_rt = 1'b0;
        endcase
        w_stall = valid_q && idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == w_rs) || (w_uses_rt && (idex_rt_i == w_rt)));
    end

    // ------------------------------------------------------------------
    // Next-state: a flush always wins, even over a pending stall or hold,
    // so the squashed fetch is replaced by a bubble immediately.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = pc_i;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!(w_stall || hold_i)) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q    <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign valid_o    = valid_q;
    assign stall_o    = w_stall;
    assign bubble_o   = w_stall;
    assign pc_write_o = ~(w_stall | hold_i);

`ifdef IF_ID_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters. A hold without a hazard is not a
    // load-use stall and is deliberately not counted.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + c_CNT_ONE;
        end
        if (flush_i && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Self-checking bench for if_id_stage. A behavioural model of
//               the pipeline register is compared against the DUT on every
//               falling edge; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    localparam int          TB_CNT_W = 4;
    localparam logic [31:0] TB_NOP   = 32'h0000_0000;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [31:0]         pc_i;
    logic [31:0]         instr_i;
    logic                hold;
    logic                flush;
    logic                memread;
    logic [4:0]          idex_rt;
    logic [31:0]         pc_o;
    logic [31:0]         instr_o;
    logic                valid_o;
    logic                stall_o;
    logic                bubble_o;
    logic                pc_write_o;
    logic [TB_CNT_W-1:0] stall_cnt_o;
    logic [TB_CNT_W-1:0] flush_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    if_id_stage #(
        .NOP_INSTR (TB_NOP),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .pc_i           (pc_i),
        .instr_i        (instr_i),
        .hold_i         (hold),
        .flush_i        (flush),
        .idex_memread_i (memread),
        .idex_rt_i      (idex_rt),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .valid_o        (valid_o),
        .stall_o        (stall_o),
        .bubble_o       (bubble_o),
        .pc_write_o     (pc_write_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = TB_NOP;
    bit          m_valid = 1'b0;
    int          m_scnt  = 0;
    int          m_fcnt  = 0;
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    // Does the instruction in IF/ID read register r before it can be forwarded?
    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic [5:0] op;
        bit         rt_is_src;
        op        = ins[31:26];
        rt_is_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        return (ins[25:21] == r) || (rt_is_src && (ins[20:16] == r));
    endfunction

    function automatic bit model_stall();
        return m_valid && memread && (idex_rt != 5'd0) && reads_reg(m_instr, idex_rt);
    endfunction

    always @(posedge clk) begin
        bit s;
        s = model_stall();
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = TB_NOP; m_valid = 1'b0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (s && m_scnt < CNT_MAX) m_scnt = m_scnt + 1;
            if (flush && m_fcnt < CNT_MAX) m_fcnt = m_fcnt + 1;
            if (flush) begin
                m_pc = pc_i; m_instr = TB_NOP; m_valid = 1'b0;
            end else if (!s && !hold) begin
                m_pc = pc_i; m_instr = instr_i; m_valid = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            bit s;
            s = model_stall();
            check("m_pc",       pc_o,              m_pc);
            check("m_instr",    instr_o,           m_instr);
            check("m_valid",    {31'd0, valid_o},  {31'd0, m_valid});
            check("m_stall",    {31'd0, stall_o},  {31'd0, s});
            check("m_bubble",   {31'd0, bubble_o}, {31'd0, s});
            check("m_pc_write", {31'd0, pc_write_o}, {31'd0, !(s || hold)});
`ifdef IF_ID_PERF_CNT_EN
            check("m_stall_cnt", {28'd0, stall_cnt_o}, m_scnt);
            check("m_flush_cnt", {28'd0, flush_cnt_o}, m_fcnt);
`else
            check("m_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);
            check("m_flush_cnt", {28'd0, flush_cnt_o}, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; pc_i = 32'h40; instr_i = 32'h8C22_0004;
        hold = 1'b0; flush = 1'b0; memread = 1'b0; idex_rt = 5'd0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_pc",       pc_o, 32'h0);
        check("rst_instr",    instr_o, 32'h0);
        check("rst_valid",    {31'd0, valid_o}, 32'd0);
        check("rst_pc_write", {31'd0, pc_write_o}, 32'd1);

        // In-order capture with one cycle latency.
        rst_n = 1'b1; pc_i = 32'h4; instr_i = 32'h2001_0005;
        tick();
        check("cap1_pc", pc_o, 32'h4);
        check("cap1_instr", instr_o, 32'h2001_0005);
        check("cap1_valid", {31'd0, valid_o}, 32'd1);
        pc_i = 32'h8; instr_i = 32'h2002_0007;
        tick();
        check("cap2_instr", instr_o, 32'h2002_0007);
        pc_i = 32'hC; instr_i = 32'h0022_1820;
        tick();
        check("cap3_pc", pc_o, 32'hC);

        // Load-use: add $4,$2,$3 behind lw $2.
        pc_i = 32'h10; instr_i = 32'h0043_2020;
        tick();
        memread = 1'b1; idex_rt = 5'd2; pc_i = 32'h14; instr_i = 32'h0064_2822;
        #1;
        check("lu_stall",    {31'd0, stall_o}, 32'd1);
        check("lu_bubble",   {31'd0, bubble_o}, 32'd1);
        check("lu_pc_write", {31'd0, pc_write_o}, 32'd0);
        tick();
        check("lu_hold_pc",    pc_o, 32'h10);
        check("lu_hold_instr", instr_o, 32'h0043_2020);
        memread = 1'b0;
        #1;
        check("lu_release", {31'd0, stall_o}, 32'd0);
        tick();
        check("lu_next_instr", instr_o, 32'h0064_2822);

        // rt=0 never stalls, even when it matches rs=$0.
        pc_i = 32'h18; instr_i = 32'h0000_1020;
        tick();
        memread = 1'b1; idex_rt = 5'd0;
        #1;
        check("rt0_no_stall", {31'd0, stall_o}, 32'd0);
        memread = 1'b0; idex_rt = 5'd2; pc_i = 32'h1C; instr_i = 32'h8C62_0000;
        tick();
        // lw $2,0($3): rt is a destination, so a match on rt alone is no hazard.
        memread = 1'b1;
        #1;
        check("lw_rt_no_stall", {31'd0, stall_o}, 32'd0);
        pc_i = 32'h20; instr_i = 32'hAC62_0000;
        tick();
        // sw $2,0($3): rt is a source.
        check("sw_rt_stall", {31'd0, stall_o}, 32'd1);

        // Hold while stalled: both hold, stall persists.
        hold = 1'b1; pc_i = 32'h24;
        tick();
        check("hs_pc", pc_o, 32'h20);
        check("hs_stall", {31'd0, stall_o}, 32'd1);

        // Flush beats stall and hold.
        flush = 1'b1; pc_i = 32'h100;
        tick();
        check("fl_instr", instr_o, 32'h0);
        check("fl_valid", {31'd0, valid_o}, 32'd0);
        check("fl_pc", pc_o, 32'h100);
        check("fl_stall", {31'd0, stall_o}, 32'd0);
        flush = 1'b0;

        // External hold alone.
        memread = 1'b0; pc_i = 32'h104; instr_i = 32'h2003_0001;
        #1;
        check("hold_pc_write", {31'd0, pc_write_o}, 32'd0);
        tick();
        check("hold_pc", pc_o, 32'h100);
        hold = 1'b0;
        tick();
        check("unhold_pc", pc_o, 32'h104);

        // Counters: reset, three flushes, then a long stall.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_i = 32'h200 + 32'(i * 4);
            tick();
        end
        flush = 1'b0;
`ifdef IF_ID_PERF_CNT_EN
        check("flush_cnt3", {28'd0, flush_cnt_o}, 32'd3);
`else
        check("flush_cnt_tied", {28'd0, flush_cnt_o}, 32'd0);
`endif
        pc_i = 32'h300; instr_i = 32'h0043_2020;
        tick();
        memread = 1'b1; idex_rt = 5'd2;
        for (int i = 0; i < 20; i++) tick();
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cnt_sat", {28'd0, stall_cnt_o}, 32'hF);
`else
        check("stall_cnt_tied", {28'd0, stall_cnt_o}, 32'd0);
`endif
        check("long_stall_pc", pc_o, 32'h300);
        rst_n = 1'b0;
        tick();
        check("cnt_rst_stall", {28'd0, stall_cnt_o}, 32'd0);
        check("cnt_rst_flush", {28'd0, flush_cnt_o}, 32'd0);
        memread = 1'b0; rst_n = 1'b1;
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
